// File: rtl/rpm_calc.sv
// rpm_calc: converts an averaged pulse period (clk ticks per pulse) into RPM
// using a multi-cycle restoring divider, RPM = floor((CLK_HZ*60/PPR) / period).
// A conversion starts automatically whenever period_in differs from the last
// value converted; changes arriving mid-conversion wait for the next IDLE cycle.
module rpm_calc #(
  parameter int CLK_HZ         = 50000000,
  parameter int PULSES_PER_REV = 1,
  parameter int PERIOD_WIDTH   = 32,
  parameter int RPM_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PERIOD_WIDTH-1:0] period_in,
  output logic [RPM_WIDTH-1:0]    rpm,
  output logic                    rpm_valid,
  output logic                    overflow,
  output logic                    busy
);

  // Dividend is a constant, so the divider only needs to shift in its bits.
  localparam logic [63:0] NUM = (64'(CLK_HZ) * 64'd60) / 64'(PULSES_PER_REV);
  localparam int NUM_WIDTH = $clog2(NUM + 64'd1);
  localparam logic [NUM_WIDTH-1:0] NUM_BITS = NUM[NUM_WIDTH-1:0];
  localparam int CNT_WIDTH = (NUM_WIDTH > 1) ? $clog2(NUM_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [PERIOD_WIDTH-1:0] divisor, divisor_n;
  logic [PERIOD_WIDTH-1:0] last_period, last_period_n;
  logic [PERIOD_WIDTH:0]   rem, rem_n;
  logic [NUM_WIDTH-1:0]    quotient, quotient_n;
  logic [CNT_WIDTH-1:0]    bit_cnt, bit_cnt_n;
  logic [RPM_WIDTH-1:0]    rpm_n;
  logic                    rpm_valid_n;
  logic                    overflow_n;
  logic [PERIOD_WIDTH+1:0] trial;
  logic [63:0]             q_ext;

  assign busy = (state != IDLE);

  // Register all state; synchronous reset abandons any running conversion.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    if (rst) begin
      state       <= IDLE;
      divisor     <= '0;
      last_period <= '0;
      rem         <= '0;
      quotient    <= '0;
      bit_cnt     <= '0;
      rpm         <= '0;
      rpm_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      divisor     <= divisor_n;
      last_period <= last_period_n;
      rem         <= rem_n;
      quotient    <= quotient_n;
      bit_cnt     <= bit_cnt_n;
      rpm         <= rpm_n;
      rpm_valid   <= rpm_valid_n;
      overflow    <= overflow_n;
    end
  end

  // Next-state, divider step and result formatting.
  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_n       = state;
    divisor_n     = divisor;
    last_period_n = last_period;
    rem_n         = rem;
    quotient_n    = quotient;
    bit_cnt_n     = bit_cnt;
    rpm_n         = rpm;
    rpm_valid_n   = 1'b0;
    overflow_n    = overflow;
    trial         = {rem, NUM_BITS[bit_cnt]};
    q_ext         = 64'(quotient);

    case (state)
      IDLE: begin
        if (period_in != last_period) begin
          divisor_n     = period_in;
          last_period_n = period_in;
          rem_n         = '0;
          quotient_n    = '0;
          bit_cnt_n     = CNT_WIDTH'(NUM_WIDTH - 1);
          // A zero period means no pulses: skip the divider, report 0 RPM.
          state_n       = (period_in != '0) ? DIV : DONE;
        end
      end

      DIV: begin
        // Restoring step; remainder stays below divisor, so the low bits of
        // the subtraction are exact.
        if (trial >= {2'b00, divisor}) begin
          rem_n               = trial[PERIOD_WIDTH:0] - {1'b0, divisor};
          quotient_n[bit_cnt] = 1'b1;
        end else begin
          rem_n               = trial[PERIOD_WIDTH:0];
          quotient_n[bit_cnt] = 1'b0;
        end
        if (bit_cnt == '0) begin
          state_n = DONE;
        end else begin
          bit_cnt_n = bit_cnt - CNT_WIDTH'(1);
        end
      end

      DONE: begin
        // Saturate results that do not fit the display width.
        if (q_ext > ((64'd1 << RPM_WIDTH) - 64'd1)) begin
          rpm_n      = '1;
          overflow_n = 1'b1;
        end else begin
          rpm_n      = q_ext[RPM_WIDTH-1:0];
          overflow_n = 1'b0;
        end
        rpm_valid_n = 1'b1;
        state_n     = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rpm_calc.sv
// Self-checking bench for rpm_calc: directed scenarios plus randomized period
// sequences compared cycle by cycle against a transaction-level reference.
module tb_rpm_calc;

  localparam int CLK_HZ         = 1000000;
  localparam int PULSES_PER_REV = 1;
  localparam int PERIOD_WIDTH   = 32;
  localparam int RPM_WIDTH      = 16;
  localparam longint NUM        = (longint'(CLK_HZ) * 60) / PULSES_PER_REV;
  localparam int NUM_WIDTH      = $clog2(NUM + 1);
  localparam int CONV_EDGES     = NUM_WIDTH + 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [PERIOD_WIDTH-1:0] period_in = '0;
  logic [RPM_WIDTH-1:0]    rpm;
  logic                    rpm_valid;
  logic                    overflow;
  logic                    busy;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  bit chk_en = 1'b0;

  rpm_calc #(
    .CLK_HZ        (CLK_HZ),
    .PULSES_PER_REV(PULSES_PER_REV),
    .PERIOD_WIDTH  (PERIOD_WIDTH),
    .RPM_WIDTH     (RPM_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .period_in(period_in),
    .rpm      (rpm),
    .rpm_valid(rpm_valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference result: floor division with saturation to the display width.
  function automatic logic [RPM_WIDTH:0] ref_result(input longint period);
    longint q;
    if (period == 0) return '0;
    q = NUM / period;
    if (q > (longint'(1) << RPM_WIDTH) - 1) return {1'b1, {RPM_WIDTH{1'b1}}};
    return {1'b0, RPM_WIDTH'(q)};
  endfunction

  // Transaction-level model: a conversion is "in flight" for a fixed number
  // of edges after the value is accepted; new values are accepted only when
  // nothing is in flight.
  bit                    m_idle  = 1'b1;
  longint                m_last  = 0;
  longint                m_pend  = 0;
  int                    m_cnt   = 0;
  logic [RPM_WIDTH-1:0]  m_rpm   = '0;
  logic                  m_ovf   = 1'b0;
  logic                  m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_last = 0; m_rpm = '0; m_ovf = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_idle) begin
        if (longint'(period_in) != m_last) begin
          m_last = longint'(period_in);
          m_pend = m_last;
          m_cnt  = (m_pend == 0) ? 1 : CONV_EDGES;
          m_idle = 1'b0;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          {m_ovf, m_rpm} = ref_result(m_pend);
          m_valid = 1'b1;
          m_idle  = 1'b1;
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 64'(rpm_valid), 64'(m_valid));
      check("busy", 64'(busy), 64'(!m_idle));
      check("rpm", 64'(rpm), 64'(m_rpm));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (rpm_valid) strobe_cnt++;
    end
  end

  // Drive a period, then measure edges from the latch to the strobe.
  task automatic run_conv(input string tag, input logic [PERIOD_WIDTH-1:0] p,
                          input int exp_rpm, input bit exp_ovf, input int exp_lat);
    int n;
    n = 0;
    period_in = p;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
    end while (!rpm_valid && n < 100);
    check({tag, "_strobe"}, 64'(rpm_valid), 64'd1);
    check({tag, "_latency"}, 64'(n - 1), 64'(exp_lat));
    check({tag, "_rpm"}, 64'(rpm), 64'(exp_rpm));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    @(negedge clk);
  endtask

  // Wait (bounded) for the next strobe; returns edges waited.
  task automatic wait_strobe(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rpm_valid && n < 100);
    check({tag, "_strobe"}, 64'(rpm_valid), 64'd1);
  endtask

  initial begin
    int n;
    logic [PERIOD_WIDTH-1:0] p;
    int hold;

    // Reset and idle with a zero period: no conversions expected.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_rpm", 64'(rpm), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    repeat (50) @(negedge clk);
    check("idle_no_strobe", 64'(strobe_cnt), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Basic conversions, including saturation and recovery.
    run_conv("p60000", 32'd60000, 1000, 1'b0, CONV_EDGES);
    run_conv("p7", 32'd7, 65535, 1'b1, CONV_EDGES);
    run_conv("p1000", 32'd1000, 60000, 1'b0, CONV_EDGES);

    // Change during DIV: first result uses the latched value, the new value
    // converts after a single IDLE cycle.
    period_in = 32'd60000;
    repeat (11) @(posedge clk);
    @(negedge clk);
    period_in = 32'd12345;
    wait_strobe("mid_first", n);
    check("mid_first_rpm", 64'(rpm), 64'd1000);
    wait_strobe("mid_second", n);
    check("mid_second_gap", 64'(n), 64'(CONV_EDGES + 1));
    check("mid_second_rpm", 64'(rpm), 64'd4860);
    @(negedge clk);

    // Reset in the middle of a conversion abandons it.
    period_in = 32'd30000;
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rpm", 64'(rpm), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(rpm_valid), 64'd0);
    rst = 1'b0;
    run_conv("after_rst", 32'd30000, 2000, 1'b0, CONV_EDGES);

    // Zero period after a nonzero result.
    run_conv("p0", 32'd0, 0, 1'b0, 1);

    // Randomized sequences, checked cycle by cycle against the model.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: p = '0;
        1: p = PERIOD_WIDTH'($urandom_range(1, 10));
        2: p = PERIOD_WIDTH'($urandom_range(900, 65535));
        3: p = PERIOD_WIDTH'($urandom);
        default: p = PERIOD_WIDTH'($urandom_range(1, 2000000));
      endcase
      period_in = p;
      rst = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      rst = 1'b0;
      hold = $urandom_range(1, 35);
      repeat (hold) @(negedge clk);
    end

    // Let any last conversion drain.
    repeat (CONV_EDGES + 5) @(negedge clk);
    check("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
